// File: rtl/sqrt_pkg.sv
// Shared constants, field widths, FSM encoding and flag layout for the f32 sqrt issuer.
package sqrt_pkg;

    localparam int unsigned F32_W      = 32;
    localparam int unsigned F32_EXP_W  = 8;
    localparam int unsigned F32_MANT_W = 23;

    localparam logic [F32_W-1:0] F32_QNAN      = 32'h7fc0_0000;
    localparam logic [F32_W-1:0] F32_PINF      = 32'h7f80_0000;
    localparam logic [F32_W-1:0] F32_QUIET_BIT = 32'h0040_0000;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    typedef enum logic [1:0] {
        StIdle = ST_IDLE,
        StHold = ST_HOLD,
        StRun  = ST_RUN,
        StResp = ST_RESP
    } state_e;

    localparam int unsigned FLAG_TIMEOUT = 0;
    localparam int unsigned FLAG_BYPASS  = 1;

    localparam logic [1:0] FLAGS_NONE    = 2'b00;
    localparam logic [1:0] FLAGS_TIMEOUT = 2'b01 << FLAG_TIMEOUT;
    localparam logic [1:0] FLAGS_BYPASS  = 2'b01 << FLAG_BYPASS;

endpackage

// File: rtl/sqrt_f32_issuer_if.sv
// Operand stream, core control and result stream of the sqrt issuer.
interface sqrt_f32_issuer_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;

    logic        core_rst;
    logic [31:0] core_a;
    logic        core_rdy;
    logic [31:0] core_sqrt;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sqrt;
    logic [1:0]  out_flags;

    modport master (
        input  in_valid, in_a, core_rdy, core_sqrt, out_ready,
        output in_ready, core_rst, core_a, out_valid, out_sqrt, out_flags
    );

    modport slave (
        output in_valid, in_a, core_rdy, core_sqrt, out_ready,
        input  in_ready, core_rst, core_a, out_valid, out_sqrt, out_flags
    );

endinterface

// File: rtl/f32_classify.sv
// Combinational IEEE-754 single-precision classifier for the sqrt special cases.
module f32_classify
    import sqrt_pkg::*;
(
    input  logic [F32_W-1:0] a_i,
    output logic             is_zero_o,
    output logic             is_neg_o,
    output logic             is_inf_o,
    output logic             is_nan_o
);

    logic [F32_EXP_W-1:0]  exp_w;
    logic [F32_MANT_W-1:0] mant_w;

    assign exp_w  = a_i[F32_W-2 -: F32_EXP_W];
    assign mant_w = a_i[F32_MANT_W-1:0];

    assign is_zero_o = (a_i[F32_W-2:0] == '0);
    assign is_neg_o  = a_i[F32_W-1];
    assign is_inf_o  = (exp_w == '1) && (mant_w == '0);
    assign is_nan_o  = (exp_w == '1) && (mant_w != '0);

endmodule

// File: rtl/sqrt_f32_issuer.sv
// Sequencer feeding the sqrt core through its reset-to-start protocol, with special-case
// bypass, a run watchdog and a single operation in flight.
module sqrt_f32_issuer
    import sqrt_pkg::*;
#(
    parameter int unsigned RST_HOLD = 2,
    parameter int unsigned TIMEOUT  = 4096,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    sqrt_f32_issuer_if.master    sq_if,
    output logic                 busy,
    output logic [CNT_W-1:0]     count
);

    localparam int unsigned HoldW  = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam int unsigned TimerW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_e             state_q;
    logic               en_q;
    logic [HoldW-1:0]   hold_q;
    logic [TimerW-1:0]  timer_q;
    logic               core_rst_q;
    logic [F32_W-1:0]   core_a_q;
    logic               out_valid_q;
    logic [F32_W-1:0]   out_sqrt_q;
    logic [1:0]         out_flags_q;
    logic [CNT_W-1:0]   count_q;

    logic               is_zero, is_neg, is_inf, is_nan;
    logic               bypass;
    logic [F32_W-1:0]   bypass_val;
    logic               in_ready;

    f32_classify u_classify (
        .a_i       (sq_if.in_a),
        .is_zero_o (is_zero),
        .is_neg_o  (is_neg),
        .is_inf_o  (is_inf),
        .is_nan_o  (is_nan)
    );

    // NaN takes precedence over the sign rule so negative NaNs still propagate their payload.
    always_comb begin
        bypass     = 1'b1;
        bypass_val = F32_QNAN;
        if (is_nan) begin
            bypass_val = sq_if.in_a | F32_QUIET_BIT;
        end else if (is_zero) begin
            bypass_val = sq_if.in_a;
        end else if (is_neg) begin
            bypass_val = F32_QNAN;
        end else if (is_inf) begin
            bypass_val = F32_PINF;
        end else begin
            bypass = 1'b0;
        end
    end

    // en_q keeps in_ready low until the first edge after reset release.
    assign in_ready = (state_q == StIdle) && en_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            en_q        <= 1'b0;
            hold_q      <= '0;
            timer_q     <= '0;
            core_rst_q  <= 1'b1;
            core_a_q    <= '0;
            out_valid_q <= 1'b0;
            out_sqrt_q  <= '0;
            out_flags_q <= FLAGS_NONE;
            count_q     <= '0;
        end else begin
            en_q <= 1'b1;
            unique case (state_q)
                StIdle: begin
                    if (sq_if.in_valid && in_ready) begin
                        if (bypass) begin
                            out_sqrt_q  <= bypass_val;
                            out_flags_q <= FLAGS_BYPASS;
                            out_valid_q <= 1'b1;
                            state_q     <= StResp;
                        end else begin
                            core_a_q <= sq_if.in_a;
                            hold_q   <= '0;
                            state_q  <= StHold;
                        end
                    end
                end
                StHold: begin
                    if (hold_q == HoldW'(RST_HOLD - 1)) begin
                        core_rst_q <= 1'b0;
                        timer_q    <= '0;
                        state_q    <= StRun;
                    end else begin
                        hold_q <= hold_q + HoldW'(1);
                    end
                end
                StRun: begin
                    // rdy seen on the first RUN cycle is left over from the previous run.
                    if (sq_if.core_rdy && (timer_q != '0)) begin
                        out_sqrt_q  <= sq_if.core_sqrt;
                        out_flags_q <= FLAGS_NONE;
                        out_valid_q <= 1'b1;
                        core_rst_q  <= 1'b1;
                        state_q     <= StResp;
                    end else if (timer_q == TimerW'(TIMEOUT - 1)) begin
                        out_sqrt_q  <= F32_QNAN;
                        out_flags_q <= FLAGS_TIMEOUT;
                        out_valid_q <= 1'b1;
                        core_rst_q  <= 1'b1;
                        state_q     <= StResp;
                    end else begin
                        timer_q <= timer_q + TimerW'(1);
                    end
                end
                StResp: begin
                    if (sq_if.out_ready) begin
                        out_valid_q <= 1'b0;
                        count_q     <= count_q + CNT_W'(1);
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign sq_if.in_ready  = in_ready;
    assign sq_if.core_rst  = core_rst_q;
    assign sq_if.core_a    = core_a_q;
    assign sq_if.out_valid = out_valid_q;
    assign sq_if.out_sqrt  = out_sqrt_q;
    assign sq_if.out_flags = out_flags_q;
    assign busy            = (state_q != StIdle);
    assign count           = count_q;

endmodule

// File: tb/tb_sqrt_f32_issuer.sv
// Directed bench for sqrt_f32_issuer with a behavioural reset-to-start sqrt core model.
module tb_sqrt_f32_issuer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        busy;
    logic [15:0] count;

    sqrt_f32_issuer_if bus ();

    sqrt_f32_issuer #(
        .RST_HOLD (2),
        .TIMEOUT  (64),
        .CNT_W    (16)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .sq_if (bus),
        .busy  (busy),
        .count (count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Core model: rdy rises after m_n cycles of core_rst low and stays up (stale) while held.
    int          m_n     = 40;
    logic        m_never = 1'b0;
    logic        m_stale = 1'b0;
    logic [31:0] m_res   = 32'h0;
    int          m_cnt   = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_cnt         <= 0;
            bus.core_rdy  <= 1'b0;
            bus.core_sqrt <= 32'h0;
        end else if (bus.core_rst) begin
            m_cnt <= 0;
            if (m_stale) begin
                bus.core_rdy  <= 1'b1;
                bus.core_sqrt <= 32'hdead_beef;
            end
        end else begin
            m_cnt <= m_cnt + 1;
            if (!m_never && m_cnt >= m_n - 1) begin
                bus.core_rdy  <= 1'b1;
                bus.core_sqrt <= m_res;
            end else begin
                bus.core_rdy <= 1'b0;
            end
        end
    end

    int          run_cyc = 0;
    int          a_bad   = 0;
    logic        track_a = 1'b0;
    logic [31:0] exp_a   = 32'h0;

    always @(negedge clk) begin
        if (!rst) begin
            if (!bus.core_rst) run_cyc <= run_cyc + 1;
            if (track_a && busy && bus.core_a !== exp_a) a_bad <= a_bad + 1;
        end
    end

    task automatic send_op(input logic [31:0] a);
        int k;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        k = 0;
        while (!bus.in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        check_eq("accept_ready", {31'h0, bus.in_ready}, 32'h1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_resp(output logic [31:0] res, output logic [1:0] fl, output int lat);
        lat = 0;
        @(negedge clk);
        while (!bus.out_valid && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        check_eq("resp_valid", {31'h0, bus.out_valid}, 32'h1);
        res = bus.out_sqrt;
        fl  = bus.out_flags;
    endtask

    task automatic ack();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
    endtask

    logic [31:0] byp_a   [6] = '{32'hc000_0000, 32'hff80_0000, 32'h8000_0000,
                                 32'h7f80_0000, 32'h7f80_0001, 32'h0000_0000};
    logic [31:0] byp_exp [6] = '{32'h7fc0_0000, 32'h7fc0_0000, 32'h8000_0000,
                                 32'h7f80_0000, 32'h7fc0_0001, 32'h0000_0000};

    initial begin
        logic [31:0] res, snap;
        logic [1:0]  fl;
        int          lat, r0, a0, hs, viol, n_bad_v, n_bad_s, n_bad_r;
        logic [15:0] c0;
        int          exp_count;

        bus.in_valid  = 1'b0;
        bus.in_a      = 32'h0;
        bus.out_ready = 1'b0;
        exp_count     = 0;

        // Reset state
        #2 rst = 1'b1;
        #1;
        check_eq("rst_busy", {31'h0, busy}, 32'h0);
        check_eq("rst_in_ready", {31'h0, bus.in_ready}, 32'h0);
        check_eq("rst_core_rst", {31'h0, bus.core_rst}, 32'h1);
        check_eq("rst_core_a", bus.core_a, 32'h0);
        check_eq("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
        check_eq("rst_out_sqrt", bus.out_sqrt, 32'h0);
        check_eq("rst_out_flags", {30'h0, bus.out_flags}, 32'h0);
        check_eq("rst_count", {16'h0, count}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 check_eq("rel_in_ready_low", {31'h0, bus.in_ready}, 32'h0);
        @(posedge clk);
        #1 check_eq("rel_in_ready_high", {31'h0, bus.in_ready}, 32'h1);

        // 1: normal op through the core
        m_n = 40; m_res = 32'h3fb5_04f3;
        exp_a = 32'h4000_0000; track_a = 1'b1;
        r0 = run_cyc; a0 = a_bad;
        send_op(32'h4000_0000);
        wait_resp(res, fl, lat);
        check_eq("t1_sqrt", res, 32'h3fb5_04f3);
        check_eq("t1_flags", {30'h0, fl}, 32'h0);
        check_eq("t1_latency", lat, 32'd43);
        check_eq("t1_run_span", run_cyc - r0, 32'd41);
        ack(); exp_count++;
        track_a = 1'b0;
        check_eq("t1_core_a_stable", a_bad - a0, 32'd0);
        check_eq("t1_count", {16'h0, count}, exp_count);

        // 2: special-case bypass, core never started
        r0 = run_cyc;
        for (int i = 0; i < 6; i++) begin
            send_op(byp_a[i]);
            wait_resp(res, fl, lat);
            check_eq("t2_sqrt", res, byp_exp[i]);
            check_eq("t2_flags", {30'h0, fl}, 32'h2);
            check_eq("t2_latency", lat, 32'd0);
            ack(); exp_count++;
        end
        check_eq("t2_core_rst_held", run_cyc - r0, 32'd0);
        check_eq("t2_count", {16'h0, count}, exp_count);

        // 3: watchdog abort, then a healthy op
        m_never = 1'b1;
        r0 = run_cyc;
        send_op(32'h4000_0000);
        wait_resp(res, fl, lat);
        check_eq("t3_to_sqrt", res, 32'h7fc0_0000);
        check_eq("t3_to_flags", {30'h0, fl}, 32'h1);
        check_eq("t3_to_run_span", run_cyc - r0, 32'd64);
        check_eq("t3_to_latency", lat, 32'd66);
        ack(); exp_count++;
        m_never = 1'b0; m_n = 40; m_res = 32'h3fdd_b3d7;
        send_op(32'h4040_0000);
        wait_resp(res, fl, lat);
        check_eq("t3_sqrt3", res, 32'h3fdd_b3d7);
        check_eq("t3_flags", {30'h0, fl}, 32'h0);
        ack(); exp_count++;

        // 4: stale rdy on the release cycle must be ignored
        m_stale = 1'b1; m_n = 3; m_res = 32'h3f80_0000;
        r0 = run_cyc;
        send_op(32'h3f80_0000);
        m_stale = 1'b0;
        wait_resp(res, fl, lat);
        check_eq("t4_sqrt", res, 32'h3f80_0000);
        check_eq("t4_run_span", run_cyc - r0, 32'd4);
        check_eq("t4_latency", lat, 32'd6);
        ack(); exp_count++;

        // 5a: back-pressure in RESP
        m_n = 5; m_res = 32'h3fb5_04f3;
        send_op(32'h4000_0000);
        wait_resp(res, fl, lat);
        snap = bus.out_sqrt; c0 = count;
        n_bad_v = 0; n_bad_s = 0; n_bad_r = 0;
        repeat (10) begin
            @(negedge clk);
            if (!bus.out_valid) n_bad_v++;
            if (bus.out_sqrt !== 32'h3fb5_04f3) n_bad_s++;
            if (bus.in_ready) n_bad_r++;
        end
        check_eq("t5_valid_held", n_bad_v, 32'd0);
        check_eq("t5_sqrt_stable", n_bad_s, 32'd0);
        check_eq("t5_in_ready_low", n_bad_r, 32'd0);
        check_eq("t5_count_hold", {16'h0, count}, {16'h0, c0});
        ack(); exp_count++;
        check_eq("t5_sqrt_after", bus.out_sqrt, snap);

        // 5b: back-to-back with in_valid held high
        @(negedge clk);
        c0 = count; hs = 0; viol = 0;
        bus.in_a = 32'hc000_0000; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) hs++;
            if (bus.in_ready && busy) viol++;
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        check_eq("t5_b2b_handshakes", hs, 32'd10);
        check_eq("t5_b2b_count", {16'h0, count - c0}, 32'd10);
        check_eq("t5_b2b_accept_idle", viol, 32'd0);
        exp_count += 10;
        check_eq("t5_count_total", {16'h0, count}, exp_count);

        // 6: asynchronous reset mid-RUN
        m_never = 1'b1;
        send_op(32'h4000_0000);
        repeat (8) @(negedge clk);
        check_eq("t6_in_run", {31'h0, bus.core_rst}, 32'h0);
        #2 rst = 1'b1;
        #1;
        check_eq("t6_core_rst", {31'h0, bus.core_rst}, 32'h1);
        check_eq("t6_busy", {31'h0, busy}, 32'h0);
        check_eq("t6_count", {16'h0, count}, 32'h0);
        check_eq("t6_core_a", bus.core_a, 32'h0);
        check_eq("t6_out_sqrt", bus.out_sqrt, 32'h0);
        check_eq("t6_out_valid", {31'h0, bus.out_valid}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; m_never = 1'b0; m_n = 40; m_res = 32'h3fb5_04f3;
        send_op(32'h4000_0000);
        wait_resp(res, fl, lat);
        check_eq("t6_sqrt", res, 32'h3fb5_04f3);
        check_eq("t6_flags", {30'h0, fl}, 32'h0);
        ack();
        check_eq("t6_count_after", {16'h0, count}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
